// File: rtl/sram_arbiter.sv
// Two-port (CPU / loader) arbiter and fixed-length access sequencer for the external SRAM.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU has fixed priority.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic [15:0] ldr_rdata,
  output logic        ldr_ack,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        OE,
  output logic        WE,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic        owner_q;
  logic        oe_q;
  logic        wen_q;
  logic        cpu_ack_q;
  logic        ldr_ack_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] cpu_rdata_q;
  logic [15:0] ldr_rdata_q;
`ifdef SRAM_ARB_RR_EN
  logic        last_q;
`endif

  logic        grant_ldr_d;
  logic        we_d;
  logic [15:0] addr_d;
  logic [15:0] wdata_d;

  always_comb begin
`ifdef SRAM_ARB_RR_EN
    // On a tie the port that lost the previous grant wins.
    grant_ldr_d = ldr_req & (~cpu_req | ~last_q);
`else
    grant_ldr_d = ldr_req & ~cpu_req;
`endif
    we_d    = grant_ldr_d ? ldr_we    : cpu_we;
    addr_d  = grant_ldr_d ? ldr_addr  : cpu_addr;
    wdata_d = grant_ldr_d ? ldr_wdata : cpu_wdata;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      oe_q        <= 1'b1;
      wen_q       <= 1'b1;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
      ldr_rdata_q <= 16'h0000;
`ifdef SRAM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req || ldr_req) begin
            state_q <= ACCESS;
            owner_q <= grant_ldr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= CNT_LOAD;
            // Strobes are registered, so they drop together with entry into ACCESS.
            oe_q    <= we_d;
            wen_q   <= ~we_d;
`ifdef SRAM_ARB_RR_EN
            last_q  <= grant_ldr_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            oe_q    <= 1'b1;
            wen_q   <= 1'b1;
            if (!we_q) begin
              if (owner_q) ldr_rdata_q <= Data_from_SRAM;
              else         cpu_rdata_q <= Data_from_SRAM;
            end
            if (owner_q) ldr_ack_q <= 1'b1;
            else         cpu_ack_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          oe_q    <= 1'b1;
          wen_q   <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_rdata    = cpu_rdata_q;
  assign ldr_rdata    = ldr_rdata_q;
  assign cpu_ack      = cpu_ack_q;
  assign ldr_ack      = ldr_ack_q;
  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign OE           = oe_q;
  assign WE           = wen_q;
  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=15,
// each with its own SRAM array, checked every cycle against a timing-based transaction model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset;
  logic        creq [2];
  logic        cwe  [2];
  logic        lreq [2];
  logic        lwe  [2];
  logic [15:0] caddr[2];
  logic [15:0] cwd  [2];
  logic [15:0] laddr[2];
  logic [15:0] lwd  [2];
  logic [15:0] crd  [2];
  logic [15:0] lrd  [2];
  logic [15:0] addr_w[2];
  logic [15:0] dts_w [2];
  logic [15:0] dfs_w [2];
  logic        cack [2];
  logic        lack [2];
  logic        oe_w [2];
  logic        we_w [2];
  logic        busy_w[2];
  logic        own_w[2];

  logic [15:0] mem0 [65536];
  logic [15:0] mem1 [65536];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit started = 0;

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .Clk(clk), .Reset(Reset),
    .cpu_req(creq[0]), .cpu_we(cwe[0]), .cpu_addr(caddr[0]), .cpu_wdata(cwd[0]),
    .cpu_rdata(crd[0]), .cpu_ack(cack[0]),
    .ldr_req(lreq[0]), .ldr_we(lwe[0]), .ldr_addr(laddr[0]), .ldr_wdata(lwd[0]),
    .ldr_rdata(lrd[0]), .ldr_ack(lack[0]),
    .ADDR(addr_w[0]), .Data_to_SRAM(dts_w[0]), .Data_from_SRAM(dfs_w[0]),
    .OE(oe_w[0]), .WE(we_w[0]), .busy(busy_w[0]), .owner(own_w[0])
  );

  sram_arbiter #(.WAIT_CYCLES(15)) dut15 (
    .Clk(clk), .Reset(Reset),
    .cpu_req(creq[1]), .cpu_we(cwe[1]), .cpu_addr(caddr[1]), .cpu_wdata(cwd[1]),
    .cpu_rdata(crd[1]), .cpu_ack(cack[1]),
    .ldr_req(lreq[1]), .ldr_we(lwe[1]), .ldr_addr(laddr[1]), .ldr_wdata(lwd[1]),
    .ldr_rdata(lrd[1]), .ldr_ack(lack[1]),
    .ADDR(addr_w[1]), .Data_to_SRAM(dts_w[1]), .Data_from_SRAM(dfs_w[1]),
    .OE(oe_w[1]), .WE(we_w[1]), .busy(busy_w[1]), .owner(own_w[1])
  );

  assign dfs_w[0] = mem0[addr_w[0]];
  assign dfs_w[1] = mem1[addr_w[1]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we_w[0] === 1'b0) mem0[addr_w[0]] <= dts_w[0];
    if (we_w[1] === 1'b0) mem1[addr_w[1]] <= dts_w[1];
  end

  task automatic chk16(input string name, input int k, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] @cyc %0d: got %h, want %h", name, k, cyc, got, exp);
    end
  endtask

  task automatic chk1(input string name, input int k, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] @cyc %0d: got %b, want %b", name, k, cyc, got, exp);
    end
  endtask

  // Transaction model: a grant at edge t makes the access occupy the next W cycles,
  // the ack cycle follows, and the port is idle again W+2 edges after the grant.
  int          wc [2] = '{2, 15};
  bit          m_act  [2];
  int          m_n    [2];
  bit          m_port [2];
  bit          m_we   [2];
  bit          m_last [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wd   [2];
  logic [15:0] m_rd   [2][2];
  bit          m_was_idle;
  bit          m_win;

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_n[k] = 0; m_port[k] = 0; m_we[k] = 0; m_last[k] = 1;
        m_addr[k] = 16'h0000; m_wd[k] = 16'h0000;
        m_rd[k][0] = 16'h0000; m_rd[k][1] = 16'h0000;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_was_idle = !m_act[k];
        if (m_act[k]) begin
          m_n[k] = m_n[k] + 1;
          if (m_n[k] == wc[k] + 1 && !m_we[k])
            m_rd[k][m_port[k]] = (k == 0) ? mem0[m_addr[k]] : mem1[m_addr[k]];
          if (m_n[k] == wc[k] + 2) m_act[k] = 0;
        end
        if (m_was_idle && (creq[k] || lreq[k])) begin
          if (creq[k] && lreq[k]) begin
`ifdef SRAM_ARB_RR_EN
            m_win = !m_last[k];
`else
            m_win = 0;
`endif
          end else begin
            m_win = lreq[k];
          end
          m_last[k] = m_win;
          m_port[k] = m_win;
          m_we[k]   = m_win ? lwe[k] : cwe[k];
          m_addr[k] = m_win ? laddr[k] : caddr[k];
          m_wd[k]   = m_win ? lwd[k] : cwd[k];
          m_act[k]  = 1;
          m_n[k]    = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk1 ("busy",  k, busy_w[k], m_act[k]);
        chk1 ("OE",    k, oe_w[k], !(m_act[k] && m_n[k] <= wc[k] && !m_we[k]));
        chk1 ("WE",    k, we_w[k], !(m_act[k] && m_n[k] <= wc[k] && m_we[k]));
        chk1 ("cpu_ack", k, cack[k], m_act[k] && m_n[k] == wc[k] + 1 && !m_port[k]);
        chk1 ("ldr_ack", k, lack[k], m_act[k] && m_n[k] == wc[k] + 1 && m_port[k]);
        chk1 ("owner", k, own_w[k], m_port[k]);
        chk16("ADDR",  k, addr_w[k], m_addr[k]);
        chk16("Data_to_SRAM", k, dts_w[k], m_wd[k]);
        chk16("cpu_rdata", k, crd[k], m_rd[k][0]);
        chk16("ldr_rdata", k, lrd[k], m_rd[k][1]);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of the ack cycle with req dropped.
  task automatic access(input int k, input bit port, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int oe_n, output int we_n);
    bit seen;
    seen = 0; oe_n = 0; we_n = 0;
    if (!port) begin creq[k] = 1; cwe[k] = w; caddr[k] = a; cwd[k] = d; end
    else       begin lreq[k] = 1; lwe[k] = w; laddr[k] = a; lwd[k] = d; end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (oe_w[k] == 1'b0) oe_n++;
      if (we_w[k] == 1'b0) we_n++;
      if ((port ? lack[k] : cack[k]) == 1'b1) seen = 1;
    end
    chk1("ack_seen", k, seen, 1'b1);
    if (!port) creq[k] = 0; else lreq[k] = 0;
    $display("access dut%0d port=%0d we=%0d addr=%h wdata=%h oe_low=%0d we_low=%0d",
             k, port, w, a, d, oe_n, we_n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int oe_n, we_n;
    int ports[$];
    int times[$];
    int exp_ports[4];
    int acks, t1, t2, oe1, oe2, busy_low;

    Reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      creq[k] = 0; cwe[k] = 0; lreq[k] = 0; lwe[k] = 0;
      caddr[k] = 16'h0; cwd[k] = 16'h0; laddr[k] = 16'h0; lwd[k] = 16'h0;
    end
    mem0[16'h3000] = 16'hBEEF;
    mem1[16'h0100] = 16'h1111;
    mem1[16'h0101] = 16'h2222;
    #2 Reset = 1'b0;
    #1 started = 1;
    repeat (3) @(negedge clk);
    chk16("rst_ADDR", 0, addr_w[0], 16'h0000);
    chk1 ("rst_OE",   0, oe_w[0], 1'b1);
    chk1 ("rst_busy", 0, busy_w[0], 1'b0);
    Reset = 1'b1;
    @(negedge clk);

    // CPU read
    access(0, 0, 0, 16'h3000, 16'h0000, oe_n, we_n);
    chk16("rd_oe_cycles", 0, 16'(oe_n), 16'd2);
    chk16("rd_we_cycles", 0, 16'(we_n), 16'd0);
    chk16("rd_data", 0, crd[0], 16'hBEEF);

    // Loader write, then loader read-back
    access(0, 1, 1, 16'h0010, 16'h1234, oe_n, we_n);
    chk16("wr_we_cycles", 0, 16'(we_n), 16'd2);
    chk16("wr_mem", 0, mem0[16'h0010], 16'h1234);
    chk1 ("wr_owner", 0, own_w[0], 1'b1);
    chk16("wr_ldr_rdata", 0, lrd[0], 16'h0000);
    access(0, 1, 0, 16'h0010, 16'h0000, oe_n, we_n);
    chk16("ldr_rd_data", 0, lrd[0], 16'h1234);
    chk16("ldr_rd_cpu_hold", 0, crd[0], 16'hBEEF);

    // Both ports requesting continuously
    @(negedge clk);
    creq[0] = 1; cwe[0] = 0; caddr[0] = 16'h3000;
    lreq[0] = 1; lwe[0] = 0; laddr[0] = 16'h0010;
    for (int i = 0; i < 60 && ports.size() < 4; i++) begin
      @(negedge clk);
      if (cack[0]) begin ports.push_back(0); times.push_back(cyc); end
      if (lack[0]) begin ports.push_back(1); times.push_back(cyc); end
    end
    creq[0] = 0; lreq[0] = 0;
`ifdef SRAM_ARB_RR_EN
    exp_ports = '{0, 1, 0, 1};
`else
    exp_ports = '{0, 0, 0, 0};
`endif
    chk16("tie_acks", 0, 16'(ports.size()), 16'd4);
    for (int i = 0; i < ports.size(); i++) begin
      $display("tie grant %0d -> port %0d at cyc %0d", i, ports[i], times[i]);
      chk16("tie_port", 0, 16'(ports[i]), 16'(exp_ports[i]));
      if (i > 0) chk16("tie_spacing", 0, 16'(times[i] - times[i-1]), 16'd4);
    end

    // Reset in the first ACCESS cycle of a write
    @(negedge clk);
    @(negedge clk);
    lreq[0] = 1; lwe[0] = 1; laddr[0] = 16'h0040; lwd[0] = 16'h5555;
    @(posedge clk);
    #1;
    chk1("rst_mid_we_low", 0, we_w[0], 1'b0);
    Reset = 1'b0;
    lreq[0] = 0;
    #1;
    chk1 ("rst_mid_we",    0, we_w[0], 1'b1);
    chk1 ("rst_mid_oe",    0, oe_w[0], 1'b1);
    chk1 ("rst_mid_busy",  0, busy_w[0], 1'b0);
    chk1 ("rst_mid_ack",   0, lack[0], 1'b0);
    chk1 ("rst_mid_owner", 0, own_w[0], 1'b0);
    chk16("rst_mid_ADDR",  0, addr_w[0], 16'h0000);
    chk16("rst_mid_dts",   0, dts_w[0], 16'h0000);
    chk16("rst_mid_crd",   0, crd[0], 16'h0000);
    chk16("rst_mid_lrd",   0, lrd[0], 16'h0000);
    $display("reset mid-access applied at cyc %0d", cyc);
    @(negedge clk);
    Reset = 1'b1;

    // First tie after reset goes to the CPU in both arbitration modes
    creq[0] = 1; cwe[0] = 0; caddr[0] = 16'h3000;
    lreq[0] = 1; lwe[0] = 0; laddr[0] = 16'h0010;
    acks = 0;
    for (int i = 0; i < 20 && acks == 0; i++) begin
      @(negedge clk);
      if (cack[0] || lack[0]) begin
        acks = 1;
        chk1("post_rst_tie_cpu", 0, cack[0], 1'b1);
        chk16("post_rst_tie_data", 0, crd[0], 16'hBEEF);
      end
    end
    creq[0] = 0; lreq[0] = 0;
    chk16("post_rst_tie_seen", 0, 16'(acks), 16'd1);
    $display("post-reset tie resolved at cyc %0d", cyc);

    // Back-to-back CPU reads with WAIT_CYCLES = 15
    @(negedge clk);
    creq[1] = 1; cwe[1] = 0; caddr[1] = 16'h0100;
    acks = 0; t1 = 0; t2 = 0; oe1 = 0; oe2 = 0; busy_low = 0;
    for (int i = 0; i < 80 && acks < 2; i++) begin
      @(negedge clk);
      if (oe_w[1] == 1'b0) begin
        if (acks == 0) oe1++; else oe2++;
      end
      if (acks == 1 && busy_w[1] == 1'b0) busy_low++;
      if (cack[1]) begin
        acks++;
        if (acks == 1) begin
          t1 = cyc;
          chk16("b2b_rd1", 1, crd[1], 16'h1111);
          caddr[1] = 16'h0101;
        end else begin
          t2 = cyc;
          chk16("b2b_rd2", 1, crd[1], 16'h2222);
        end
      end
    end
    creq[1] = 0;
    $display("b2b reads: acks=%0d t1=%0d t2=%0d oe1=%0d oe2=%0d busy_low=%0d",
             acks, t1, t2, oe1, oe2, busy_low);
    chk16("b2b_acks", 1, 16'(acks), 16'd2);
    chk16("b2b_oe1", 1, 16'(oe1), 16'd15);
    chk16("b2b_oe2", 1, 16'(oe2), 16'd15);
    chk16("b2b_spacing", 1, 16'(t2 - t1), 16'd17);
    chk16("b2b_busy_low", 1, 16'(busy_low), 16'd1);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the single external SRAM on the SLC-3 board. It shares the SRAM between the CPU memory port (Mem2IO side, MAR/MDR traffic) and a program-loader/debug port. Each access runs as a fixed-length strobe sequence with a registered address, data and read-data path. It sits between the two requesters and the top-level SRAM pins (ADDR, Data_to_SRAM, Data_from_SRAM, OE, WE).

## Interface
- WAIT_CYCLES, 2, number of cycles the OE/WE strobe is held low per access; legal range 1..15.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req = 1.
- cpu_addr  in  16  CPU word address.
- cpu_wdata  in  16  CPU write data.
- cpu_rdata  out  16  registered read data for the CPU.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/16/16  loader port; same meaning as the CPU port.
- ldr_rdata  out  16  registered read data for the loader.
- ldr_ack  out  1  one-cycle completion pulse to the loader.
- ADDR  out  16  SRAM address, registered.
- Data_to_SRAM  out  16  SRAM write data, registered.
- Data_from_SRAM  in  16  SRAM read data.
- OE  out  1  SRAM output enable, active-low.
- WE  out  1  SRAM write enable, active-low.
- busy  out  1  1 whenever state ≠ IDLE.
- owner  out  1  port that owns the current or most recent access: 0 = CPU, 1 = loader.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - No request: remain in IDLE.
  - Any request: select a winner. Latch its we into the internal we_l, its address into ADDR and its write data into Data_to_SRAM. Set owner, load the counter with WAIT_CYCLES-1, and go to ACCESS.
- **ACCESS**
  - OE = 0 if we_l = 0; otherwise WE = 0. The other strobe stays 1.
  - The counter decrements each cycle. When the counter = 0: on a read, capture Data_from_SRAM into the owner's rdata register, then go to DONE.
- **DONE**
  - OE = WE = 1.
  - The owner's ack = 1 for this single cycle, then go to IDLE.
  - DONE never grants a new request.
- Arbitration with a single request: that port always wins.
- Arbitration with both requesting: rule set by the configuration macro (see Configuration).
- ADDR, Data_to_SRAM and the non-owner rdata register hold their values outside a transaction. rdata is never changed by a write.
- Requesters must drop req on the edge that ends the ack cycle. If req is still high in IDLE, it is a new request.
- Request inputs change only when sampled in IDLE. Changes to a port's inputs during ACCESS/DONE have no effect on the transaction in flight.

## Timing
- Reset values (asynchronous, Reset = 0):
  - state = IDLE; OE = WE = 1
  - cpu_ack = ldr_ack = 0; busy = 0
  - ADDR = Data_to_SRAM = cpu_rdata = ldr_rdata = 16'h0000
  - owner = 0; round-robin last-owner = 1
- Grant edge t (request sampled in IDLE):
  - ACCESS spans cycles t+1 .. t+WAIT_CYCLES.
  - DONE/ack is in cycle t+WAIT_CYCLES+1.
  - Back in IDLE at t+WAIT_CYCLES+2.
  - Minimum request-to-request period is WAIT_CYCLES+2 cycles.
- ADDR and Data_to_SRAM are stable from the first ACCESS cycle through DONE. Strobes are low only in ACCESS.
- Read data is valid in the owner's rdata register from the DONE cycle onward, coincident with ack.
- Reset asserted mid-ACCESS: strobes go high immediately and no ack is issued; the transaction is lost.
- Reset released: the first possible grant is on the first rising edge with Reset = 1.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the port that did not win the previous grant (last-owner) wins.
  - last-owner updates on every grant.
  - The first tie after reset goes to the CPU.
- SRAM_ARB_RR_EN undefined: fixed priority; the CPU always wins a tie and the loader can starve.

## Test plan
- **CPU read, WAIT_CYCLES = 2.**
  - Stimulus: preload SRAM model 16'h3000 = 16'hBEEF; cpu_req = 1, cpu_we = 0, cpu_addr = 16'h3000.
  - Required: OE low for exactly 2 cycles; cpu_ack one cycle in DONE with cpu_rdata = 16'hBEEF; WE stays high.
- **Loader write.**
  - Stimulus: ldr_req = 1, ldr_we = 1, ldr_addr = 16'h0010, ldr_wdata = 16'h1234.
  - Required: WE low 2 cycles with ADDR = 16'h0010 and Data_to_SRAM = 16'h1234; ldr_ack pulses; owner = 1; ldr_rdata unchanged.
- **Tie, fixed priority (macro undefined).**
  - Stimulus: both ports request continuously for 3 grants.
  - Required: 3 CPU grants, zero ldr_ack.
- **Tie, SRAM_ARB_RR_EN defined.**
  - Stimulus: both ports request continuously.
  - Required: grants alternate CPU, loader, CPU, loader; acks spaced WAIT_CYCLES+2 cycles apart.
- **Reset mid-access.**
  - Stimulus: assert Reset in the first ACCESS cycle of a write.
  - Required: WE = 1 and state = IDLE immediately; no ack; all outputs at reset values.
- **Back-to-back CPU reads, WAIT_CYCLES = 15.**
  - Stimulus: two consecutive CPU reads.
  - Required: each access's OE low exactly 15 cycles; second ack 17 cycles after the first; busy low only in the IDLE cycle between accesses.
